// File: rtl/qsys_sysid_pkg.sv
// Shared constants for the system-ID register block: the word address map,
// the CONTROL bit positions and a byte-lane merge helper.
package qsys_sysid_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [ADDR_W-1:0] ADDR_ID        = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_VERSION   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_LO = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_HI = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_CLK_FREQ  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL   = 3'd7;

  localparam int unsigned CTRL_CLEAR_BIT  = 0;
  localparam int unsigned CTRL_FREEZE_BIT = 1;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] wdata,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = cur;
    for (int n = 0; n < BE_W; n++) begin
      if (be[n]) begin
        res[8*n +: 8] = wdata[8*n +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/qsys_sysid_regs_if.sv
// Avalon-MM slave bus for the system-ID block: fixed read latency of one
// cycle, no waitrequest.
interface qsys_sysid_regs_if;
  import qsys_sysid_pkg::*;

  // Handshake: read/write are single-cycle strobes sampled on every rising
  // edge and always accepted (no back-pressure). readdatavalid is high for
  // exactly the one cycle after each accepted read; readdata holds otherwise.
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/qsys_sysid_uptime.sv
// Free-running uptime counter with clear/freeze control and a shadow copy of
// the upper bits captured when the low word is read.
module qsys_sysid_uptime #(
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             freeze,
  input  logic             snap,
  output logic [31:0]      count,
  output logic [CNT_W-33:0] shadow
);

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-33:0] shadow_q;
  logic [CNT_W-33:0] shadow_d;

  // Clear wins over freeze and increment; the snapshot always sees the
  // value from before this edge, so a read racing a clear gets the old count.
  always_comb begin
    count_d  = count_q;
    shadow_d = shadow_q;
    if (clear) begin
      count_d = '0;
    end else if (!freeze) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (snap) begin
      shadow_d = count_q[CNT_W-1:32];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end

  assign count  = count_q[31:0];
  assign shadow = shadow_q;

endmodule

// File: rtl/qsys_sysid_regs.sv
// System identification register block: constant ID words, a scratch word,
// a 64-bit-capable uptime counter and a control word, on an Avalon-MM slave.
module qsys_sysid_regs
  import qsys_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter logic [31:0] CLK_FREQ_HZ = 32'd50_000_000,
  parameter int          CNT_W       = 64
) (
  input logic               clock,
  input logic               reset,
  qsys_sysid_regs_if.slave  bus
);

  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic              freeze_q, freeze_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic [DATA_W-1:0] rd_mux;
  logic              ctrl_wr;
  logic              clear;
  logic              snap;
  logic [31:0]       up_count;
  logic [CNT_W-33:0] up_shadow;

  assign ctrl_wr = bus.write && (bus.address == ADDR_CONTROL) && bus.byteenable[0];
  assign clear   = ctrl_wr && bus.writedata[CTRL_CLEAR_BIT];
  assign snap    = bus.read && (bus.address == ADDR_UPTIME_LO);

  qsys_sysid_uptime #(
    .CNT_W (CNT_W)
  ) u_uptime (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .freeze (freeze_q),
    .snap   (snap),
    .count  (up_count),
    .shadow (up_shadow)
  );

  // Read mux sees only registered state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_ID:        rd_mux = SYSTEM_ID;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_VERSION:   rd_mux = VERSION;
      ADDR_SCRATCH:   rd_mux = scratch_q;
      ADDR_UPTIME_LO: rd_mux = up_count;
      ADDR_UPTIME_HI: rd_mux = 32'(up_shadow);
      ADDR_CLK_FREQ:  rd_mux = CLK_FREQ_HZ;
      ADDR_CONTROL:   rd_mux[CTRL_FREEZE_BIT] = freeze_q;
      default:        rd_mux = '0;
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    freeze_d  = freeze_q;
    rvalid_d  = bus.read;
    rdata_d   = rdata_q;
    if (bus.read) begin
      rdata_d = rd_mux;
    end
    if (bus.write && (bus.address == ADDR_SCRATCH)) begin
      scratch_d = merge_bytes(scratch_q, bus.writedata, bus.byteenable);
    end
    if (ctrl_wr) begin
      freeze_d = bus.writedata[CTRL_FREEZE_BIT];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= '0;
      freeze_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      freeze_q  <= freeze_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule

// File: tb/tb_qsys_sysid_regs.sv
// Bench for qsys_sysid_regs: a 64-bit and a 33-bit counter instance share one
// stimulus stream and are checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_qsys_sysid_regs;
  import qsys_sysid_pkg::*;

  localparam logic [31:0] SYS_ID = 32'h574E_72B7;
  localparam logic [31:0] TS     = 32'h6650_1A2B;
  localparam logic [31:0] VER    = 32'h0002_0003;
  localparam logic [31:0] FREQ   = 32'd100_000_000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  qsys_sysid_regs_if bus_a ();
  qsys_sysid_regs_if bus_b ();

  qsys_sysid_regs #(
    .SYSTEM_ID (SYS_ID), .TIMESTAMP (TS), .VERSION (VER),
    .CLK_FREQ_HZ (FREQ), .CNT_W (64)
  ) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a)
  );

  qsys_sysid_regs #(
    .SYSTEM_ID (SYS_ID), .TIMESTAMP (TS), .VERSION (VER),
    .CLK_FREQ_HZ (FREQ), .CNT_W (33)
  ) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b)
  );

  // ---------------- reference model ----------------
  int errors = 0;
  int checks = 0;

  longint unsigned m_cnt [2];
  longint unsigned m_mask [2];
  logic [31:0]     m_shadow [2];
  logic [31:0]     m_last [2];
  logic [31:0]     m_scratch;
  logic            m_freeze;

  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  logic [63:0] frc_a;
  logic [32:0] frc_b;

  function automatic logic [31:0] model_read(input int i, input logic [2:0] a);
    case (a)
      3'd0:    return SYS_ID;
      3'd1:    return TS;
      3'd2:    return VER;
      3'd3:    return m_scratch;
      3'd4:    return m_cnt[i][31:0];
      3'd5:    return m_shadow[i];
      3'd6:    return FREQ;
      default: return {30'd0, m_freeze, 1'b0};
    endcase
  endfunction

  task automatic model_edge(input logic rd, input logic wr, input logic [2:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input logic rst);
    logic clr;
    logic [31:0] e;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_shadow[i] = '0; m_last[i] = '0;
      end
      m_scratch = '0;
      m_freeze  = 1'b0;
    end else begin
      clr = wr && (a == 3'd7) && be[0] && wd[0];
      for (int i = 0; i < 2; i++) begin
        if (rd) begin
          e = model_read(i, a);
          if (i == 0) exp_q_a.push_back(e); else exp_q_b.push_back(e);
          m_last[i] = e;
          if (a == 3'd4) m_shadow[i] = 32'(m_cnt[i] >> 32);
        end
        if (clr) m_cnt[i] = 0;
        else if (!m_freeze) m_cnt[i] = (m_cnt[i] + 1) & m_mask[i];
      end
      if (wr && a == 3'd3) begin
        for (int n = 0; n < 4; n++) begin
          if (be[n]) m_scratch[8*n +: 8] = wd[8*n +: 8];
        end
      end
      if (wr && a == 3'd7 && be[0]) m_freeze = wd[1];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input logic rst);
    bus_a.read = rd; bus_a.write = wr; bus_a.address = a;
    bus_a.writedata = wd; bus_a.byteenable = be;
    bus_b.read = rd; bus_b.write = wr; bus_b.address = a;
    bus_b.writedata = wd; bus_b.byteenable = be;
    reset = rst;
    @(posedge clock);
    model_edge(rd, wr, a, wd, be, rst);
    @(negedge clock);
  endtask

  task automatic rd_word(input logic [2:0] a);
    step(1'b1, 1'b0, a, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic wr_word(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    step(1'b0, 1'b1, a, wd, be, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
  endtask

  // Preload both counters between edges; called right after a step returns.
  task automatic force_counts(input logic [63:0] va, input logic [32:0] vb);
    frc_a = va;
    frc_b = vb;
    force dut_a.u_uptime.count_q = frc_a;
    force dut_b.u_uptime.count_q = frc_b;
    m_cnt[0] = va;
    m_cnt[1] = 64'(vb);
    #1;
    release dut_a.u_uptime.count_q;
    release dut_b.u_uptime.count_q;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon_check(input int i, input logic v, input logic [31:0] d);
    logic        exp_v;
    logic [31:0] e;
    exp_v = (i == 0) ? (exp_q_a.size() != 0) : (exp_q_b.size() != 0);
    checks++;
    if (v !== exp_v) begin
      errors++;
      $display("FAIL rvalid[%0d] t=%0t actual=%b required=%b", i, $time, v, exp_v);
    end
    if (exp_v) begin
      e = (i == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL rdata[%0d] t=%0t actual=%h required=%h", i, $time, d, e);
      end
    end else begin
      checks++;
      if (d !== m_last[i]) begin
        errors++;
        $display("FAIL rdata_hold[%0d] t=%0t actual=%h required=%h", i, $time, d, m_last[i]);
      end
    end
  endtask

  always @(negedge clock) begin
    mon_check(0, bus_a.readdatavalid, bus_a.readdata);
    mon_check(1, bus_b.readdatavalid, bus_b.readdata);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] ra;
    m_mask[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    m_mask[1] = 64'h1_FFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_shadow[i] = '0; m_last[i] = '0;
    end
    m_scratch = '0;
    m_freeze  = 1'b0;

    // Reads issued while reset is high must be dropped.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'd4, 32'd0, 4'd0, 1'b1);
    rd_word(3'd4);
    rd_word(3'd4);

    rd_word(3'd0); rd_word(3'd1); rd_word(3'd2); rd_word(3'd6);

    wr_word(3'd3, 32'hDEAD_BEEF, 4'b0101);
    rd_word(3'd3);
    step(1'b1, 1'b1, 3'd3, 32'h1234_5678, 4'hF, 1'b0);
    rd_word(3'd3);
    wr_word(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr_word(3'd6, 32'h0BAD_F00D, 4'hF);
    rd_word(3'd0); rd_word(3'd6);
    rd_word(3'd4); rd_word(3'd5);

    // Freeze, hold, then clear.
    wr_word(3'd7, 32'd2, 4'hF);
    idle(10);
    rd_word(3'd4); rd_word(3'd4); rd_word(3'd7);
    wr_word(3'd7, 32'd1, 4'hF);
    rd_word(3'd4); rd_word(3'd7);
    wr_word(3'd7, 32'hFFFF_FFFF, 4'hF);
    rd_word(3'd4); rd_word(3'd4); rd_word(3'd7);
    wr_word(3'd7, 32'd0, 4'hF);
    idle(3);

    // Low-word boundary and 33-bit wrap.
    force_counts(64'h0000_0000_FFFF_FFFE, 33'h1_FFFF_FFFE);
    rd_word(3'd4); rd_word(3'd5);
    rd_word(3'd4); rd_word(3'd5);
    force_counts(64'hFFFF_FFFF_FFFF_FFFD, 33'h1_FFFF_FFFD);
    rd_word(3'd4); rd_word(3'd5);
    idle(1);
    rd_word(3'd4); rd_word(3'd5);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      ra = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ra,
           $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    wr_word(3'd7, 32'd0, 4'hF);

    // Reset in the middle of a run.
    idle(25);
    rd_word(3'd4);
    step(1'b1, 1'b0, 3'd4, 32'd0, 4'd0, 1'b1);
    step(1'b1, 1'b1, 3'd3, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd_word(3'd4); rd_word(3'd4); rd_word(3'd5); rd_word(3'd3); rd_word(3'd7);
    idle(3);

    checks++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d required=0/0", exp_q_a.size(), exp_q_b.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qsys_sysid_regs.md
QSYS_SYSID_REGS -- requirements
Module: qsys_sysid_regs

Interface
REQ-001 Parameter: SYSTEM_ID, default 32'h0000_0000, system identifier returned at word 0.
REQ-002 Parameter: TIMESTAMP, default 32'h0000_0000, build timestamp (Unix seconds) returned at word 1.
REQ-003 Parameter: VERSION, default 32'h0001_0000, major[31:16]/minor[15:0] returned at word 2.
REQ-004 Parameter: CLK_FREQ_HZ, default 50_000_000, clock frequency returned at word 6.
REQ-005 Parameter: CNT_W, default 64, legal range 33..64, uptime counter width.
REQ-006 Port: clock  in  1  single clock; all logic is on its rising edge.
REQ-007 Port: reset  in  1  synchronous, active-high reset.
REQ-008 Port: address  in  3  Avalon-MM word address.
REQ-009 Port: read  in  1  read request, single cycle, no waitrequest.
REQ-010 Port: write  in  1  write request, single cycle, no waitrequest.
REQ-011 Port: writedata  in  32  write data.
REQ-012 Port: byteenable  in  4  write byte lanes; bit n enables writedata[8n+7:8n].
REQ-013 Port: readdata  out  32  registered read data.
REQ-014 Port: readdatavalid  out  1  high one cycle when readdata is valid.

Function
REQ-015 Map: 0 SYSTEM_ID (RO), 1 TIMESTAMP (RO), 2 VERSION (RO), 3 SCRATCH (RW), 4 UPTIME_LO (RO), 5 UPTIME_HI (RO), 6 CLK_FREQ_HZ (RO), 7 CONTROL (RW).
REQ-016 Read latency is fixed at 1: read in cycle N gives readdatavalid=1 and readdata in cycle N+1.
REQ-017 readdatavalid is 0 in every cycle not following a read; readdata holds its last value when readdatavalid=0.
REQ-018 The uptime counter increments by 1 every cycle unless CONTROL.FREEZE=1, and wraps from 2^CNT_W-1 to 0.
REQ-019 A read of word 4 returns counter[31:0] and in the same cycle latches counter[CNT_W-1:32] into a shadow register.
REQ-020 A read of word 5 returns the shadow register zero-extended to 32 bits, never the live upper bits.
REQ-021 CONTROL bit0 CLEAR is write-1-to-act: the counter becomes 0 in the next cycle; the bit reads 0.
REQ-022 CONTROL bit1 FREEZE is RW and stores the value written; bits [31:2] read 0 and ignore writes.
REQ-023 SCRATCH writes update only the enabled byte lanes; writes to RO words are ignored.
REQ-024 Simultaneous read and write to the same word: the read returns the pre-write value, and the write takes effect.
REQ-025 CLEAR written in the same cycle as a word-4 read: the read returns the pre-clear count, and the shadow latches the pre-clear upper bits.
REQ-026 CLEAR has priority over increment; FREEZE=1 with CLEAR still clears the counter.

Reset
REQ-027 In every cycle with reset=1: readdata=0, readdatavalid=0, counter=0, shadow=0, SCRATCH=0, FREEZE=0.
REQ-028 A read asserted in the same cycle as reset is discarded: no readdatavalid follows it.
REQ-029 After reset deasserts, the counter reads 1 in the first following cycle and keeps counting.

Structure
REQ-030 The address constants (ADDR_ID..ADDR_CONTROL) and the CONTROL bit indices SHALL be placed in the shared package qsys_sysid_pkg.
REQ-031 The uptime counter with its shadow register SHALL be the sub-module qsys_sysid_uptime (ports: clear, freeze, snap, count, shadow).

Verification
REQ-032 Reads of words 0,1,2,6 with SYSTEM_ID=32'h574E72B7 -> 32'h574E72B7, TIMESTAMP, VERSION, and CLK_FREQ_HZ, each one cycle later with readdatavalid=1.
REQ-033 Write SCRATCH=32'hDEADBEEF with byteenable=4'b0101 after reset -> a read returns 32'h00AD00EF.
REQ-034 Force the counter to 32'hFFFF_FFFE via CLEAR plus a timed run, then read word 4 followed by word 5 -> LO=FFFF_FFFE and HI=0, with no carry leaking into HI.
REQ-035 CNT_W=33, run to 2^33-1 -> the next cycle counts 0, and a word-5 read after a word-4 read returns 0 or 1 as latched.
REQ-036 Write CONTROL=2, wait 10 cycles, read word 4 twice -> both values are equal; then write CONTROL=1 -> word 4 reads 0.
REQ-037 Read asserted with reset=1 -> readdatavalid stays 0; reset mid-count -> word 4 restarts from a small value.
